// File: rtl/top_k_pkg.sv
// Shared constants for the top-k line format, used by both the receive-side
// line parser and the transmit-side result packer.
//   - word format: {clear, tlast, data[31:0]}
//   - opcodes carried in the control line
//   - control-line fill pattern and opcode field position
//   - keep_for_words(): byte-enable mask for a line holding n 32-bit words
package top_k_pkg;

  localparam int unsigned WORDS_PER_LINE = 16;
  localparam int unsigned ACC_WORDS      = 15;

  // Bit positions inside the 34-bit stream word.
  localparam int unsigned CLEAR_BIT = 33;
  localparam int unsigned TLAST_BIT = 32;

  // Opcodes carried in the control line.
  localparam logic [15:0] OP_ECHO  = 16'h0000;
  localparam logic [15:0] OP_TOP_K = 16'h0001;
  localparam logic [15:0] OP_MM    = 16'h0002;

  // Control-line layout: fill in the low bits, opcode at [495:480].
  localparam int unsigned CTRL_FILL_W = 448;
  localparam logic [447:0] CTRL_FILL  = {448{1'b1}};
  localparam int unsigned OPCODE_LSB  = 480;
  localparam int unsigned OPCODE_MSB  = 495;

  // What the packer does with the word at the head of the input stream.
  typedef enum logic [2:0] {
    ACT_IDLE  = 3'd0,
    ACT_STORE = 3'd1,
    ACT_EMIT  = 3'd2,
    ACT_FLUSH = 3'd3,
    ACT_CTRL  = 3'd4
  } pack_act_e;

  // Byte enables for n_words (0..16) words, contiguous from bit 0.
  // A shift by 64 yields zero, so n_words=16 gives all ones.
  function automatic logic [63:0] keep_for_words(input logic [4:0] n_words);
    return ~(64'hFFFF_FFFF_FFFF_FFFF << {n_words, 2'b00});
  endfunction

endpackage

// File: rtl/result_packer_top_k_line_out_reg.sv
// Output holding stage for one 512-bit line plus its keep/last sideband.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load              capture load_* into the register (only when out_free)
//   load_data/keep/last  line to capture
//   tx_TREADY         downstream ready
//   tx_TDATA/TKEEP/TLAST/TVALID  registered line towards the network
//   out_free          register can accept a new line this cycle
module line_out_reg (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [511:0] load_data,
  input  logic [63:0]  load_keep,
  input  logic         load_last,
  input  logic         tx_TREADY,
  output logic [511:0] tx_TDATA,
  output logic [63:0]  tx_TKEEP,
  output logic         tx_TLAST,
  output logic         tx_TVALID,
  output logic         out_free
);

  logic [511:0] data_r;
  logic [63:0]  keep_r;
  logic         last_r;
  logic         valid_r;

  assign out_free  = !valid_r || tx_TREADY;
  assign tx_TDATA  = data_r;
  assign tx_TKEEP  = keep_r;
  assign tx_TLAST  = last_r;
  assign tx_TVALID = valid_r;

  // Line register: a load may coincide with a drain, keeping valid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r  <= 512'd0;
      keep_r  <= 64'd0;
      last_r  <= 1'b0;
      valid_r <= 1'b0;
    end else if (load) begin
      data_r  <= load_data;
      keep_r  <= load_keep;
      last_r  <= load_last;
      valid_r <= 1'b1;
    end else if (tx_TREADY) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

endmodule

// File: rtl/result_packer_top_k.sv
// Packs the 34-bit top-k word stream {clear, tlast, data} into 512-bit TCP
// transmit lines and rebuilds the control line for clear/opcode markers.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   rx_TDATA/TVALID/TREADY        input word stream
//   tx_TDATA/TKEEP/TLAST/TVALID/TREADY  output line stream
//   msg_count                     lines sent with TLAST (wraps)
//   line_count                    lines sent (wraps)
module result_packer_top_k
  import top_k_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [33:0]  rx_TDATA,
  input  logic         rx_TVALID,
  output logic         rx_TREADY,
  output logic [511:0] tx_TDATA,
  output logic [63:0]  tx_TKEEP,
  output logic         tx_TLAST,
  output logic         tx_TVALID,
  input  logic         tx_TREADY,
  output logic [31:0]  msg_count,
  output logic [31:0]  line_count
);

  logic [479:0] acc_r;
  logic [3:0]   idx_r;
  logic [31:0]  msg_count_r;
  logic [31:0]  line_count_r;

  logic         head_clear_s;
  logic         head_last_s;
  logic [31:0]  head_data_s;
  logic         completes_s;
  logic         out_free_s;
  logic         ready_s;
  logic [8:0]   slot_lsb_s;
  pack_act_e    act_s;

  logic         load_s;
  logic [511:0] line_s;
  logic [63:0]  keep_s;
  logic         last_s;

  assign head_clear_s = rx_TDATA[CLEAR_BIT];
  assign head_last_s  = rx_TDATA[TLAST_BIT];
  assign head_data_s  = rx_TDATA[31:0];
  // A data word closes the line if it is the message end or fills slot 15.
  assign completes_s  = !head_clear_s && (head_last_s || (idx_r == 4'd15));
  assign slot_lsb_s   = {idx_r, 5'b00000};

  assign rx_TREADY  = ready_s;
  assign msg_count  = msg_count_r;
  assign line_count = line_count_r;

  // Decide acceptance and action for the head word. A clear word with a
  // partial line pending first forces a flush cycle in which it is refused.
  always_comb begin
    ready_s = 1'b0;
    act_s   = ACT_IDLE;
    if (rst) begin
      ready_s = 1'b0;
      act_s   = ACT_IDLE;
    end else if (head_clear_s) begin
      if (idx_r == 4'd0) begin
        ready_s = out_free_s;
        act_s   = (rx_TVALID && out_free_s) ? ACT_CTRL : ACT_IDLE;
      end else begin
        ready_s = 1'b0;
        act_s   = (rx_TVALID && out_free_s) ? ACT_FLUSH : ACT_IDLE;
      end
    end else if (completes_s) begin
      ready_s = out_free_s;
      act_s   = (rx_TVALID && out_free_s) ? ACT_EMIT : ACT_IDLE;
    end else begin
      // Accumulator-only writes never touch the output register.
      ready_s = 1'b1;
      act_s   = rx_TVALID ? ACT_STORE : ACT_IDLE;
    end
  end

  // Build the line to load; unused slots come from the zeroed accumulator.
  always_comb begin
    load_s = 1'b0;
    line_s = 512'd0;
    keep_s = 64'd0;
    last_s = 1'b0;
    case (act_s)
      ACT_EMIT: begin
        load_s = 1'b1;
        line_s = {32'd0, acc_r};
        line_s[slot_lsb_s +: 32] = head_data_s;
        keep_s = keep_for_words({1'b0, idx_r} + 5'd1);
        last_s = head_last_s;
      end
      ACT_FLUSH: begin
        load_s = 1'b1;
        line_s = {32'd0, acc_r};
        keep_s = keep_for_words({1'b0, idx_r});
        last_s = 1'b1;
      end
      ACT_CTRL: begin
        load_s = 1'b1;
        line_s[CTRL_FILL_W-1:0]       = CTRL_FILL;
        line_s[OPCODE_MSB:OPCODE_LSB] = head_data_s[15:0];
        keep_s = 64'hFFFF_FFFF_FFFF_FFFF;
        last_s = 1'b1;
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // Accumulator and slot index.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= 480'd0;
      idx_r <= 4'd0;
    end else begin
      case (act_s)
        ACT_STORE: begin
          acc_r[slot_lsb_s +: 32] <= head_data_s;
          idx_r <= idx_r + 4'd1;
        end
        ACT_EMIT, ACT_FLUSH, ACT_CTRL: begin
          acc_r <= 480'd0;
          idx_r <= 4'd0;
        end
        default: begin
          acc_r <= acc_r;
          idx_r <= idx_r;
        end
      endcase
    end
  end

  // Line and message counters, stepped on each transmit handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_count_r <= 32'd0;
      msg_count_r  <= 32'd0;
    end else if (tx_TVALID && tx_TREADY) begin
      line_count_r <= line_count_r + 32'd1;
      msg_count_r  <= tx_TLAST ? (msg_count_r + 32'd1) : msg_count_r;
    end else begin
      line_count_r <= line_count_r;
      msg_count_r  <= msg_count_r;
    end
  end

  line_out_reg u_line_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .load_data (line_s),
    .load_keep (keep_s),
    .load_last (last_s),
    .tx_TREADY (tx_TREADY),
    .tx_TDATA  (tx_TDATA),
    .tx_TKEEP  (tx_TKEEP),
    .tx_TLAST  (tx_TLAST),
    .tx_TVALID (tx_TVALID),
    .out_free  (out_free_s)
  );

endmodule

// File: tb/tb_result_packer_top_k.sv
// Testbench for result_packer_top_k: table of single-line messages, hand
// sequences for flush/stall/reset corners, and a randomized stream checked
// against a queue-based message model.
module tb_result_packer_top_k;

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    logic         last;
  } line_t;

  typedef struct {
    int          nwords;
    logic [63:0] keep;
  } msg_vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [33:0]  rx_TDATA;
  logic         rx_TVALID;
  logic         rx_TREADY;
  logic [511:0] tx_TDATA;
  logic [63:0]  tx_TKEEP;
  logic         tx_TLAST;
  logic         tx_TVALID;
  logic         tx_TREADY;
  logic [31:0]  msg_count;
  logic [31:0]  line_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_lines = 0;
  int exp_msgs  = 0;
  int tready_mode = 0;   // 0: always ready, 1: toggle, 2: random
  int cyc = 0;

  line_t       exp_q[$];
  logic [31:0] pend[$];
  line_t       last_seen;
  line_t       held;
  line_t       mon_got;
  line_t       mon_exp;
  logic        stall_prev = 1'b0;
  msg_vec_t    tab[5];

  result_packer_top_k dut (
    .clk        (clk),
    .rst        (rst),
    .rx_TDATA   (rx_TDATA),
    .rx_TVALID  (rx_TVALID),
    .rx_TREADY  (rx_TREADY),
    .tx_TDATA   (tx_TDATA),
    .tx_TKEEP   (tx_TKEEP),
    .tx_TLAST   (tx_TLAST),
    .tx_TVALID  (tx_TVALID),
    .tx_TREADY  (tx_TREADY),
    .msg_count  (msg_count),
    .line_count (line_count)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    tx_TREADY = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tready_mode)
        0:       tx_TREADY = 1'b1;
        1:       tx_TREADY = ~tx_TREADY;
        default: tx_TREADY = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic chk_line(input string name, input logic [511:0] act, input logic [511:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference model: collect message words, emit a line every 16 words or at
  // tlast; a clear marker first closes any partial message, then emits the
  // control line.
  task automatic push_data_line(input logic last);
    line_t l;
    l.data = '0;
    foreach (pend[k]) l.data[32*k +: 32] = pend[k];
    l.keep = 64'hFFFF_FFFF_FFFF_FFFF >> (64 - 4 * pend.size());
    l.last = last;
    exp_q.push_back(l);
    pend.delete();
  endtask

  task automatic model_accept(input logic [33:0] w);
    line_t l;
    if (w[33]) begin
      if (pend.size() != 0) push_data_line(1'b1);
      l.data = '0;
      l.data[447:0]   = {448{1'b1}};
      l.data[495:480] = w[15:0];
      l.keep = 64'hFFFF_FFFF_FFFF_FFFF;
      l.last = 1'b1;
      exp_q.push_back(l);
    end else begin
      pend.push_back(w[31:0]);
      if (w[32] || pend.size() == 16) push_data_line(w[32]);
    end
  endtask

  // Monitor at the falling edge: handshakes here complete at the next rise.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      mon_got.data = tx_TDATA;
      mon_got.keep = tx_TKEEP;
      mon_got.last = tx_TLAST;
      if (stall_prev) begin
        chk_line("hold_data", mon_got.data, held.data);
        chk("hold_keep", mon_got.keep, held.keep);
        chk("hold_last_valid", {62'd0, mon_got.last, tx_TVALID}, {62'd0, held.last, 1'b1});
      end
      if (rx_TVALID && rx_TREADY) model_accept(rx_TDATA);
      if (tx_TVALID && tx_TREADY) begin
        if (exp_q.size() == 0) begin
          chk_line("unexpected_line", tx_TDATA, 512'd0);
          if (tx_TDATA === 512'd0) begin
            n_fail++;
            $display("FAIL unexpected_line: got a line, required none");
          end
        end else begin
          mon_exp = exp_q.pop_front();
          chk_line("line_data", mon_got.data, mon_exp.data);
          chk("line_keep", mon_got.keep, mon_exp.keep);
          chk("line_last", 64'(mon_got.last), 64'(mon_exp.last));
          exp_lines++;
          if (mon_exp.last) exp_msgs++;
        end
        last_seen = mon_got;
      end
      stall_prev = tx_TVALID && !tx_TREADY;
      held = mon_got;
    end
  end

  task automatic send_word(input logic [33:0] w);
    int waited = 0;
    rx_TDATA  = w;
    rx_TVALID = 1'b1;
    @(negedge clk);
    while (!rx_TREADY && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!rx_TREADY) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got rx_TREADY=0 for %0d cycles, required acceptance", waited);
    end
    @(posedge clk);
    #1;
    rx_TVALID = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    rx_TVALID   = 1'b0;
    tready_mode = 0;
    while ((exp_q.size() != 0 || tx_TVALID) && c < 300) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    chk("drain_done", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    rx_TDATA  = 34'h0_0000_0001;
    rx_TVALID = 1'b1;
    @(negedge clk);
    chk("ready_in_reset", 64'(rx_TREADY), 64'd0);
    rx_TVALID = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    pend.delete();
    exp_q.delete();
    exp_lines  = 0;
    exp_msgs   = 0;
    stall_prev = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    int start_cyc;
    int m0;
    int l0;
    logic [511:0] exp_line;
    logic [33:0]  w;

    rx_TDATA  = 34'd0;
    rx_TVALID = 1'b0;
    rst       = 1'b1;

    tab[0] = '{nwords: 3,  keep: 64'h0000_0000_0000_0FFF};
    tab[1] = '{nwords: 1,  keep: 64'h0000_0000_0000_000F};
    tab[2] = '{nwords: 16, keep: 64'hFFFF_FFFF_FFFF_FFFF};
    tab[3] = '{nwords: 4,  keep: 64'h0000_0000_0000_FFFF};
    tab[4] = '{nwords: 15, keep: 64'h0FFF_FFFF_FFFF_FFFF};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_tvalid", 64'(tx_TVALID), 64'd0);
    chk_line("rst_tdata", tx_TDATA, 512'd0);
    chk("rst_tkeep", tx_TKEEP, 64'd0);
    chk("rst_tlast", 64'(tx_TLAST), 64'd0);
    chk("rst_counts", {msg_count, line_count}, 64'd0);
    @(posedge clk);
    #1;

    // 16 words 0..15 as one full message, no bubbles
    start_cyc = cyc;
    for (int k = 0; k < 16; k++) send_word({1'b0, (k == 15), 32'(k)});
    chk("full_latency_valid", 64'(tx_TVALID), 64'd1);
    chk("full_cycles", 64'(cyc - start_cyc), 64'd16);
    drain();
    exp_line = '0;
    for (int k = 0; k < 16; k++) exp_line[32*k +: 32] = 32'(k);
    chk_line("full_data", last_seen.data, exp_line);
    chk("full_keep", last_seen.keep, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("full_msgs", 64'(msg_count), 64'd1);

    // Table of single-line messages
    for (int i = 0; i < 5; i++) begin
      m0 = int'(msg_count);
      for (int k = 0; k < tab[i].nwords; k++)
        send_word({1'b0, (k == tab[i].nwords - 1), 32'(i * 256) + 32'hA + 32'(k)});
      drain();
      chk("tab_keep", last_seen.keep, tab[i].keep);
      chk("tab_last", 64'(last_seen.last), 64'd1);
      chk("tab_msgs", 64'(msg_count), 64'(m0 + 1));
      if (i == 0)
        chk_line("abc_line", last_seen.data, {416'd0, 96'h0000000C_0000000B_0000000A});
    end

    // 20-word message spans two lines
    l0 = int'(line_count);
    for (int k = 0; k < 20; k++) send_word({1'b0, (k == 19), 32'h100 + 32'(k)});
    drain();
    chk("w20_lines", 64'(line_count), 64'(l0 + 2));
    chk("w20_keep", last_seen.keep, 64'h0000_0000_0000_FFFF);

    // Partial message closed by a clear marker
    l0 = int'(line_count);
    m0 = int'(msg_count);
    send_word({2'b00, 32'h11});
    send_word({2'b00, 32'h22});
    rx_TDATA  = {2'b10, 32'h0000_0001};
    rx_TVALID = 1'b1;
    @(negedge clk);
    chk("flush_ready", 64'(rx_TREADY), 64'd0);
    send_word({2'b10, 32'h0000_0001});
    drain();
    chk("ctrl_opcode", 64'(last_seen.data[495:480]), 64'h1);
    chk_line("ctrl_fill", {64'd0, last_seen.data[447:0]}, {64'd0, {448{1'b1}}});
    chk("ctrl_keep", last_seen.keep, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("flush_lines", {32'(line_count), 32'(msg_count)}, {32'(l0 + 2), 32'(m0 + 2)});

    // 48-word stream with downstream stalling every other cycle
    l0 = int'(line_count);
    tready_mode = 1;
    for (int k = 0; k < 48; k++) send_word({1'b0, (k == 47), 32'hBEEF_0000 + 32'(k)});
    drain();
    chk("stall_lines", 64'(line_count), 64'(l0 + 3));

    // Reset mid-message discards the partial line
    for (int k = 0; k < 5; k++) send_word({2'b00, 32'h5500 + 32'(k)});
    do_reset();
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_idle", {32'(tx_TVALID), line_count}, 64'd0);
    end
    @(posedge clk);
    #1;
    send_word({2'b01, 32'hCAFE_0001});
    drain();
    chk("post_rst_keep", last_seen.keep, 64'h0000_0000_0000_000F);
    chk_line("post_rst_data", last_seen.data, {480'd0, 32'hCAFE_0001});

    // Randomized stream against the model
    tready_mode = 2;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 15) == 0)
        w = {1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom_range(0, 2))};
      else
        w = {1'b0, ($urandom_range(0, 7) == 0), 32'($urandom)};
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      tready_mode = 2;
      send_word(w);
    end
    send_word({2'b01, 32'hFFFF_FFFF});
    drain();
    chk("rand_lines", 64'(line_count), 64'(exp_lines));
    chk("rand_msgs", 64'(msg_count), 64'(exp_msgs));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
